// File: rtl/btree_pkg.sv
// btree_pkg: shared types and helpers for the binary split tree controller.
//   state_t     - controller phases
//   leaf_w      - width of a leaf index for a given leaf count
//   node_cnt    - number of internal valve nodes (heap order)
//   child_idx   - heap child index: 2i+1 for the a-branch, 2i+2 for the b-branch
//   cnt_w       - phase counter width that cannot wrap for any phase length
package btree_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ROUTE,
        DISPENSE,
        PURGE,
        DONE
    } state_t;

    function automatic int leaf_w(input int leaves);
        return (leaves > 1) ? $clog2(leaves) : 1;
    endfunction

    function automatic int node_cnt(input int leaves);
        return leaves - 1;
    endfunction

    function automatic int child_idx(input int node, input logic dir);
        return 2 * node + 1 + int'(dir);
    endfunction

    function automatic int cnt_w(input int vol_w, input int settle_cyc, input int purge_cyc);
        int w;
        w = vol_w;
        if ($clog2(settle_cyc + 1) > w) w = $clog2(settle_cyc + 1);
        if ($clog2(purge_cyc + 1) > w) w = $clog2(purge_cyc + 1);
        return w;
    endfunction

endpackage

// File: rtl/binary_split_tree_ctrl_if.sv
// binary_split_tree_ctrl_if: host command channel of the split tree controller.
//   cmd_valid - command offered by the host
//   cmd_ready - controller can accept a command
//   cmd_leaf  - target leaf index
//   cmd_vol   - pump-on cycle count
// Modports: master (host side), slave (controller side).
interface binary_split_tree_ctrl_if
    import btree_pkg::*;
#(
    parameter int LEAVES = 32,
    parameter int VOL_W  = 8
) ();

    localparam int LW = leaf_w(LEAVES);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [LW-1:0]    cmd_leaf;
    logic [VOL_W-1:0] cmd_vol;

    modport master (
        output cmd_valid,
        output cmd_leaf,
        output cmd_vol,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_leaf,
        input  cmd_vol,
        output cmd_ready
    );

endinterface

// File: rtl/btree_path_decode.sv
// btree_path_decode: combinational leaf-to-valve decoder.
//   leaf     - target leaf index
//   path_en  - internal nodes on the root-to-leaf path (heap order)
//   path_dir - branch taken at each active node; 0 = a-branch, 1 = b-branch
// Level k consumes leaf bit (N-1-k), so the MSB steers the root valve.
module btree_path_decode
    import btree_pkg::*;
#(
    parameter int LEAVES = 32
) (
    input  logic [$clog2(LEAVES)-1:0] leaf,
    output logic [LEAVES-2:0]         path_en,
    output logic [LEAVES-2:0]         path_dir
);

    localparam int LW = leaf_w(LEAVES);

    logic [LW-1:0] node;
    logic [LW-1:0] rem;
    logic          dir_bit;

    // Walk from the root, shifting the leaf left so the steering bit is always the MSB.
    // The child index after the last level is past the node range and is discarded.
    always_comb begin
        path_en  = '0;
        path_dir = '0;
        node     = '0;
        rem      = leaf;
        dir_bit  = 1'b0;
        for (int k = 0; k < LW; k++) begin
            dir_bit        = rem[LW-1];
            path_en[node]  = 1'b1;
            path_dir[node] = dir_bit;
            node           = LW'(child_idx(int'(node), dir_bit));
            rem            = rem << 1;
        end
    end

endmodule

// File: rtl/binary_split_tree_ctrl.sv
// binary_split_tree_ctrl: sequencing controller for a 2^N-leaf fluidic split tree.
//   clk, rst   - clock; synchronous active-high reset
//   cmd        - command channel (valid/ready, leaf, vol), slave side
//   abort      - cancel the in-flight command (honoured in ROUTE and DISPENSE)
//   path_en    - valve enables for the active path
//   path_dir   - valve directions on the active path
//   pump_en    - source pump, high for exactly vol cycles
//   purge_en   - purge flow (only with BTREE_PURGE_EN)
//   done       - one-cycle completion pulse with done_leaf / done_abort
// Build option: define BTREE_PURGE_EN to include the PURGE phase; otherwise
// dispense, zero volume and abort all finish straight into DONE.
module binary_split_tree_ctrl
    import btree_pkg::*;
#(
    parameter int LEAVES     = 32,
    parameter int SETTLE_CYC = 4,
    parameter int PURGE_CYC  = 8,
    parameter int VOL_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    binary_split_tree_ctrl_if.slave       cmd,
    input  logic                          abort,
    output logic [LEAVES-2:0]             path_en,
    output logic [LEAVES-2:0]             path_dir,
    output logic                          pump_en,
    output logic                          purge_en,
    output logic                          done,
    output logic [$clog2(LEAVES)-1:0]     done_leaf,
    output logic                          done_abort
);

    localparam int LW    = leaf_w(LEAVES);
    localparam int NODES = node_cnt(LEAVES);
    localparam int CW    = cnt_w(VOL_W, SETTLE_CYC, PURGE_CYC);

    state_t           state, state_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [LW-1:0]    leaf_q, leaf_d;
    logic [VOL_W-1:0] vol_q, vol_d;
    logic             abort_q, abort_d;
    logic             ready_q;
    logic [LW-1:0]    dec_leaf;
    logic [NODES-1:0] dec_en, dec_dir;
    logic             active_d;
    state_t           after_state;
    logic [CW-1:0]    after_cnt;

    // On the accept cycle the leaf is not latched yet, so decode straight from the bus
    // so that the path is valid in the first cycle after accept.
    assign dec_leaf = (state == IDLE) ? cmd.cmd_leaf : leaf_q;

    btree_path_decode #(.LEAVES(LEAVES)) u_decode (
        .leaf     (dec_leaf),
        .path_en  (dec_en),
        .path_dir (dec_dir)
    );

    assign cmd.cmd_ready = ready_q;

`ifdef BTREE_PURGE_EN
    assign after_state = PURGE;
    assign after_cnt   = CW'(PURGE_CYC);
`else
    assign after_state = DONE;
    assign after_cnt   = '0;
`endif

    assign active_d = (state_d == ROUTE) || (state_d == DISPENSE) || (state_d == PURGE);

    // Next-state logic. cnt holds the cycles left in the current phase, loaded with the
    // full phase length on entry, so a phase ends in the cycle where cnt is 1.
    // Abort takes priority over a phase that would end naturally in the same cycle.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        leaf_d  = leaf_q;
        vol_d   = vol_q;
        abort_d = abort_q;
        case (state)
            IDLE: begin
                if (cmd.cmd_valid && ready_q) begin
                    state_d = ROUTE;
                    cnt_d   = CW'(SETTLE_CYC);
                    leaf_d  = cmd.cmd_leaf;
                    vol_d   = cmd.cmd_vol;
                    abort_d = 1'b0;
                end
            end
            ROUTE: begin
                if (abort) begin
                    state_d = after_state;
                    cnt_d   = after_cnt;
                    abort_d = 1'b1;
                end else if (cnt == CW'(1)) begin
                    if (vol_q != '0) begin
                        state_d = DISPENSE;
                        cnt_d   = CW'(vol_q);
                    end else begin
                        state_d = after_state;
                        cnt_d   = after_cnt;
                    end
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            DISPENSE: begin
                if (abort) begin
                    state_d = after_state;
                    cnt_d   = after_cnt;
                    abort_d = 1'b1;
                end else if (cnt == CW'(1)) begin
                    state_d = after_state;
                    cnt_d   = after_cnt;
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
`ifdef BTREE_PURGE_EN
            PURGE: begin
                if (cnt == CW'(1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; every output is a function of the next state so it
    // lines up with the phase it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            leaf_q     <= '0;
            vol_q      <= '0;
            abort_q    <= 1'b0;
            ready_q    <= 1'b0;
            path_en    <= '0;
            path_dir   <= '0;
            pump_en    <= 1'b0;
            done       <= 1'b0;
            done_leaf  <= '0;
            done_abort <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            leaf_q     <= leaf_d;
            vol_q      <= vol_d;
            abort_q    <= abort_d;
            ready_q    <= (state_d == IDLE);
            path_en    <= active_d ? dec_en : '0;
            path_dir   <= active_d ? dec_dir : '0;
            pump_en    <= (state_d == DISPENSE);
            done       <= (state_d == DONE);
            done_leaf  <= (state_d == DONE) ? leaf_d : '0;
            done_abort <= (state_d == DONE) ? abort_d : 1'b0;
        end
    end

`ifdef BTREE_PURGE_EN
    // Purge flow follows the PURGE phase; the path stays open meanwhile.
    always_ff @(posedge clk) begin
        if (rst) begin
            purge_en <= 1'b0;
        end else begin
            purge_en <= (state_d == PURGE);
        end
    end
`else
    assign purge_en = 1'b0;
`endif

endmodule
